// File: rtl/npc_ras_unit.sv
// npc_ras_unit: next-PC selection for the fetch stage, plus a small circular
// return-address stack (RAS) that predicts the targets of returns.
//
// Ports:
//   clk          in   sole clock; all state changes on its rising edge
//   reset        in   asynchronous, active-high
//   stall        in   freezes pc_f and the stack while high
//   npc_op       in   3'b000 plus4, 001 branch, 010 jump, 011 jumpreg,
//                     100 call, 101 return, 110/111 reserved (plus4)
//   branch_taken in   branch compare result from the D stage
//   offset       in   sign-extended 16-bit immediate (word offset)
//   instr_index  in   J-type target field
//   reg_data     in   forwarded rs value (jumpreg / return target)
//   pc_d         in   PC of the instruction in the D stage
//   pc_f         out  registered fetch PC
//   npc          out  combinational next PC
//   ras_miss     out  combinational; return target differs from stack top
//   ras_count    out  registered number of valid stack entries
module npc_ras_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic [2:0]                     npc_op,
  input  logic                           branch_taken,
  input  logic [31:0]                    offset,
  input  logic [25:0]                    instr_index,
  input  logic [31:0]                    reg_data,
  input  logic [31:0]                    pc_d,
  output logic [31:0]                    pc_f,
  output logic [31:0]                    npc,
  output logic                           ras_miss,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  localparam logic [2:0] OP_PLUS4   = 3'b000;
  localparam logic [2:0] OP_BRANCH  = 3'b001;
  localparam logic [2:0] OP_JUMP    = 3'b010;
  localparam logic [2:0] OP_JUMPREG = 3'b011;
  localparam logic [2:0] OP_CALL    = 3'b100;
  localparam logic [2:0] OP_RETURN  = 3'b101;

  // Stack entries are never reset: nothing reads them while ras_count is 0.
  logic [31:0] stack [RAS_DEPTH];
  // ptr indexes the current top entry.
  logic [PW-1:0] ptr;

  logic [31:0] plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        do_push;
  logic        do_pop;

  // Pointer increment with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(RAS_DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + {{(PW-1){1'b0}}, 1'b1};
    end
  endfunction

  // Pointer decrement with explicit wrap.
  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    if (p == {PW{1'b0}}) begin
      return PW'(RAS_DEPTH - 1);
    end else begin
      return p - {{(PW-1){1'b0}}, 1'b1};
    end
  endfunction

  assign plus4         = pc_f + 32'd4;
  assign branch_target = pc_d + 32'd4 + (offset << 2);
  assign jump_target   = {pc_d[31:28], instr_index, 2'b00};

  assign do_push = (npc_op == OP_CALL);
  // A return on an empty stack leaves pointer and count untouched.
  assign do_pop  = (npc_op == OP_RETURN) && (ras_count != {CW{1'b0}});

  // Next-PC selection; the register value always wins on return, the stack
  // only flags whether its prediction would have been right.
  always_comb begin
    npc      = plus4;
    ras_miss = 1'b0;
    case (npc_op)
      OP_PLUS4: begin
        npc = plus4;
      end
      OP_BRANCH: begin
        if (branch_taken) begin
          npc = branch_target;
        end else begin
          npc = plus4;
        end
      end
      OP_JUMP, OP_CALL: begin
        npc = jump_target;
      end
      OP_JUMPREG: begin
        npc = reg_data;
      end
      OP_RETURN: begin
        npc = reg_data;
        if (ras_count != {CW{1'b0}}) begin
          ras_miss = (stack[ptr] != reg_data);
        end else begin
          ras_miss = 1'b0;
        end
      end
      default: begin
        npc = plus4;
      end
    endcase
  end

  // Fetch PC, stack pointer and valid count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f      <= RESET_PC;
      ras_count <= {CW{1'b0}};
      ptr       <= {PW{1'b0}};
    end else if (!stall) begin
      pc_f <= npc;
      if (do_push) begin
        ptr <= ptr_inc(ptr);
        // Full stack: the slot above top is the oldest entry, so the
        // overwrite is implicit and the count saturates.
        if (ras_count != CW'(RAS_DEPTH)) begin
          ras_count <= ras_count + {{(CW-1){1'b0}}, 1'b1};
        end
      end else if (do_pop) begin
        ptr       <= ptr_dec(ptr);
        ras_count <= ras_count - {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Stack storage: a call writes its return address into the slot above top.
  always_ff @(posedge clk) begin
    if (!reset && !stall && do_push) begin
      stack[ptr_inc(ptr)] <= pc_d + 32'd8;
    end
  end

endmodule

// File: doc/npc_ras_unit.md
NPC_RAS_UNIT -- requirements
Module: npc_ras_unit

Interface
REQ-001 SHALL: parameter RESET_PC, default 32'h0000_3000, fetch PC after reset.
REQ-002 SHALL: parameter RAS_DEPTH, default 4, return-address-stack entries; legal range 2..16.
REQ-003 SHALL: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL: reset  in  1  asynchronous, active-high.
REQ-005 SHALL: stall  in  1  freezes PC register and stack when 1.
REQ-006 SHALL: npc_op  in  3  000 plus4, 001 branch, 010 jump, 011 jumpreg, 100 call, 101 return; 110/111 reserved.
REQ-007 SHALL: branch_taken  in  1  D-stage compare result.
REQ-008 SHALL: offset  in  32  sign-extended 16-bit immediate.
REQ-009 SHALL: instr_index  in  26  J-type target field.
REQ-010 SHALL: reg_data  in  32  forwarded rs value.
REQ-011 SHALL: pc_d  in  32  PC of instruction in D stage.
REQ-012 SHALL: pc_f  out  32  registered fetch PC.
REQ-013 SHALL: npc  out  32  combinational next PC.
REQ-014 SHALL: ras_miss  out  1  combinational; return target disagreed with stack top.
REQ-015 SHALL: ras_count  out  $clog2(RAS_DEPTH+1)  registered valid-entry count.

Function
REQ-016 SHALL: npc per op -- plus4: pc_f+4; branch: taken ? pc_d+4+(offset<<2) : pc_f+4; jump/call: {pc_d[31:28],instr_index,2'b00}; jumpreg: reg_data; reserved: pc_f+4.
REQ-017 SHALL: all arithmetic modulo 2^32, carries discarded.
REQ-018 SHALL: return with ras_count>0 -- npc = reg_data; ras_miss = (stack top != reg_data); reg_data always wins.
REQ-019 SHALL: return with ras_count==0 -- npc = reg_data, ras_miss = 0.
REQ-020 SHALL: ras_miss = 0 for every op other than return.
REQ-021 SHALL: pc_f <= npc on each rising edge with stall=0; pc_f holds with stall=1 (latency one cycle).
REQ-022 SHALL: call with stall=0 pushes pc_d+8 on the edge; ras_count increments, saturating at RAS_DEPTH.
REQ-023 SHALL: push at full stack is circular -- overwrites oldest entry, count stays RAS_DEPTH, newest entry becomes top.
REQ-024 SHALL: return with stall=0 and ras_count>0 pops on the edge; ras_count decrements; pop at ras_count==0 is a no-op.
REQ-025 SHALL: stall=1 inhibits push and pop; npc and ras_miss stay combinationally valid.
REQ-026 SHALL: top-of-stack pointer wraps modulo RAS_DEPTH in both directions.

Reset
REQ-027 SHALL: reset asserted -- pc_f=RESET_PC, ras_count=0, pointer=0 immediately, independent of clk.
REQ-028 SHALL: stack entry contents need no reset; they are unreadable while ras_count==0.
REQ-029 SHALL: reset mid-sequence discards pending pushes/pops; first edge after release loads npc computed from pc_f=RESET_PC.

Verification
REQ-030 SHALL: reset, then 3 plus4 edges -> pc_f 0x3000,0x3004,0x3008,0x300C; ras_count 0.
REQ-031 SHALL: branch taken, pc_d=0x3010, offset=0xFFFFFFFE -> npc 0x300C; not taken with pc_f=0x3014 -> npc 0x3018.
REQ-032 SHALL: call pc_d=0x3020, instr_index=0x0000D00 -> npc 0x00003400, push 0x3028; return with reg_data=0x3028 -> npc 0x3028, ras_miss 0, ras_count 0.
REQ-033 SHALL: RAS_DEPTH=4, 5 calls pushing A..E, then 5 returns -> tops E,D,C,B then empty (ras_miss 0 on fifth); count 4,4->3,2,1,0.
REQ-034 SHALL: return with top 0x3028, reg_data 0x4000 -> npc 0x4000, ras_miss 1, entry popped.
REQ-035 SHALL: stall=1 during call for 3 cycles -> pc_f and ras_count unchanged; push occurs once when stall drops; async reset mid-stall -> pc_f 0x3000 before next edge.
